// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the uart link arbiter and its helpers:
//   DATA_W      - width of a uart word
//   TIMEOUT_DEF - default watchdog limit in WAIT cycles
//   state_e     - arbiter FSM encoding
//   idx_w()     - width of a binary index for an N-entry vector
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_W      = 7;
    localparam int TIMEOUT_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // A 1-entry vector still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req_i for the first set bit
// starting just above rr_ptr_i and wrapping modulo NREQ.
// Ports:
//   req_i     - request vector
//   rr_ptr_i  - index of the most recently served requester
//   win_oh_o  - one-hot winner (zero when no request)
//   win_idx_o - binary index of the winner
//   any_o     - at least one request is pending
// -----------------------------------------------------------------------------
module rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   rr_ptr_i,
    output logic [NREQ-1:0] win_oh_o,
    output logic [IW-1:0]   win_idx_o,
    output logic            any_o
);

    // One extra bit so rr_ptr + offset (< 2*NREQ) cannot overflow before the wrap.
    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        found     = 1'b0;
        sum       = '0;
        cand      = '0;
        // Offset NREQ lands back on rr_ptr itself, so it is considered last.
        for (int k = 1; k <= NREQ; k++) begin
            sum = {1'b0, rr_ptr_i} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            cand = sum[IW-1:0];
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                win_idx_o      = cand;
                win_oh_o[cand] = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/uart_link_arbiter.sv
// -----------------------------------------------------------------------------
// uart_link_arbiter
// Shares one uart (transmit -> receive loop) between NREQ requesters with
// round-robin arbitration. Each transfer latches the winner's word, strobes
// uart_save once, waits for a fresh uart_ready, and returns the received word
// and error flag with a one-cycle done pulse. A watchdog ends transfers whose
// ready never arrives.
//
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   req, req_data          - request levels and packed 7-bit words
//   gnt, done              - one-hot grant, one-cycle completion pulse
//   rsp_data, rsp_err,
//   rsp_timeout            - response, valid while done != 0
//   busy                   - arbiter not idle
//   uart_save, uart_data   - strobe and word to the uart
//   uart_ready, uart_error,
//   uart_data_out          - uart receive side
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for any request; arbitrates and latches the word
// ISSUE  | single-cycle uart_save strobe, watchdog cleared
// WAIT   | waiting for a fresh uart_ready or the watchdog limit
// DONE   | done pulse to the winner, round-robin pointer advanced
// -----------------------------------------------------------------------------
module uart_link_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TW      = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [DATA_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    output logic                   rsp_timeout,
    output logic                   busy,
    output logic                   uart_save,
    output logic [DATA_W-1:0]      uart_data,
    input  logic                   uart_ready,
    input  logic                   uart_error,
    input  logic [DATA_W-1:0]      uart_data_out
);

    localparam int IW = idx_w(NREQ);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q;
    logic [IW-1:0]     idx_q;
    logic [IW-1:0]     rr_ptr_q;
    logic [DATA_W-1:0] uart_data_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic              rsp_to_q;
    logic              armed_q;
    logic [TW-1:0]     wdog_q;

    logic [NREQ-1:0]   pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic [DATA_W-1:0] req_word [NREQ];
    logic              ready_hit;
    logic              wdog_hit;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i     (req),
        .rr_ptr_i  (rr_ptr_q),
        .win_oh_o  (pick_oh),
        .win_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_word[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // armed is only set once ready has been seen low inside WAIT, so a ready
    // left high by the previous transfer cannot complete this one.
    assign ready_hit = armed_q && uart_ready;
    assign wdog_hit  = (wdog_q == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (pick_any) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (ready_hit || wdog_hit) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Transfer datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q       <= '0;
            idx_q       <= '0;
            rr_ptr_q    <= IW'(NREQ - 1);
            uart_data_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            armed_q     <= 1'b0;
            wdog_q      <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt_q       <= pick_oh;
                        idx_q       <= pick_idx;
                        uart_data_q <= req_word[pick_idx];
                    end
                end
                ST_ISSUE: begin
                    wdog_q  <= '0;
                    armed_q <= 1'b0;
                end
                ST_WAIT: begin
                    wdog_q <= wdog_q + 1'b1;
                    if (!uart_ready) begin
                        armed_q <= 1'b1;
                    end
                    // Ready takes priority when it lands on the watchdog's last cycle.
                    if (ready_hit) begin
                        rsp_data_q <= uart_data_out;
                        rsp_err_q  <= uart_error;
                        rsp_to_q   <= 1'b0;
                    end else if (wdog_hit) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                        rsp_to_q   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    rr_ptr_q <= idx_q;
                    gnt_q    <= '0;
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        gnt         = gnt_q;
        done        = '0;
        rsp_data    = '0;
        rsp_err     = 1'b0;
        rsp_timeout = 1'b0;
        busy        = (state_q != ST_IDLE);
        uart_save   = (state_q == ST_ISSUE);
        uart_data   = uart_data_q;
        if (state_q == ST_DONE) begin
            done        = gnt_q;
            rsp_data    = rsp_data_q;
            rsp_err     = rsp_err_q;
            rsp_timeout = rsp_to_q;
        end
    end

endmodule

// File: tb/tb_uart_link_arbiter.sv
module tb_uart_link_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 32;
    localparam int TW      = 6;

    localparam int M_NORM  = 0;
    localparam int M_STALE = 1;
    localparam int M_TMO   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [27:0] req_data = '0;
    logic [3:0]  gnt, done;
    logic [6:0]  rsp_data, uart_data;
    logic        rsp_err, rsp_timeout, busy, uart_save;
    logic        uart_ready = 1'b0;
    logic        uart_error = 1'b0;
    logic [6:0]  uart_data_out = '0;

    uart_link_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_data      (req_data),
        .gnt           (gnt),
        .done          (done),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .rsp_timeout   (rsp_timeout),
        .busy          (busy),
        .uart_save     (uart_save),
        .uart_data     (uart_data),
        .uart_ready    (uart_ready),
        .uart_error    (uart_error),
        .uart_data_out (uart_data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [6:0] word;
        logic [6:0] rdata;
        logic       rerr;
        logic       rto;
        int         lat;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int last  = NREQ - 1;
    logic [6:0] words [NREQ];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // Stimulus -> uart model configuration for the next transfer
    int         m_mode  = M_NORM;
    int         m_lat   = 5;
    logic [6:0] m_rdata = '0;
    logic       m_rerr  = 1'b0;

    // uart model: ready drops at save (or one cycle later in stale mode) and
    // rises lat cycles after save with the configured word; it is never
    // cleared by the uart itself.
    int         c_mode = M_NORM;
    int         c_lat = 0;
    int         m_cnt = 0;
    bit         m_active = 1'b0;
    logic [6:0] c_rdata = '0;
    logic       c_rerr = 1'b0;

    always @(negedge clk) begin
        if (uart_save) begin
            c_mode   = m_mode;
            c_lat    = m_lat;
            c_rdata  = m_rdata;
            c_rerr   = m_rerr;
            m_cnt    = 0;
            m_active = 1'b1;
            if (c_mode != M_STALE) uart_ready = 1'b0;
        end else if (m_active) begin
            m_cnt++;
            if (m_cnt == 1 && c_mode == M_STALE) uart_ready = 1'b0;
            if (c_mode != M_TMO && m_cnt == c_lat) begin
                uart_ready    = 1'b1;
                uart_data_out = c_rdata;
                uart_error    = c_rerr;
                m_active      = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    int cyc = 0;
    int save_cyc = 0;
    bit prev_save = 1'b0;
    bit busy_chk = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            prev_save = 1'b0;
            busy_chk  = 1'b0;
        end else begin
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            chk("done_subset_gnt", 32'(done & ~gnt), 32'd0);
            if (busy_chk) begin
                chk("busy_after_done", 32'(busy), 32'd0);
                chk("done_one_cycle", 32'(done), 32'd0);
                busy_chk = 1'b0;
            end
            if (uart_save) begin
                chk("save_one_cycle", 32'(prev_save), 32'd0);
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_save: uart_data=%0h, expected no save", uart_data);
                end else begin
                    chk("uart_data_at_save", 32'(uart_data), 32'(exp_q[0].word));
                    chk("gnt_at_save", 32'(gnt), 32'(1) << exp_q[0].idx);
                end
                save_cyc = cyc;
            end
            prev_save = uart_save;
            if (done != 0) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_done: done=%0h, expected none", done);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_bit", 32'(done), 32'(1) << e.idx);
                    chk("rsp_data", 32'(rsp_data), 32'(e.rdata));
                    chk("rsp_err", 32'(rsp_err), 32'(e.rerr));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(e.rto));
                    chk("uart_data_hold", 32'(uart_data), 32'(e.word));
                    // Cycles from the save (ISSUE) cycle to DONE; the arbitration
                    // cycle sits one further back.
                    chk("done_latency", 32'(cyc - save_cyc), 32'(e.lat));
                end
                busy_chk = 1'b1;
            end
        end
    end

    // Reference: first requester above the last served one, wrapping.
    function automatic int pick(input logic [3:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic load_words();
        for (int i = 0; i < NREQ; i++) req_data[i*7 +: 7] = words[i];
    endtask

    task automatic wait_save(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (uart_save) begin ok = 1'b1; return; end
        end
        n_vec++; n_err++;
        $display("FAIL save_wait: no uart_save within 10 cycles, expected one");
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done != 0) return;
        end
        n_vec++; n_err++;
        $display("FAIL done_wait: no done within 200 cycles, expected one");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_uart_save", 32'(uart_save), 32'd0);
        chk("rst_uart_data", 32'(uart_data), 32'd0);
        exp_q.delete();
        last = NREQ - 1;
        rst  = 1'b0;
    endtask

    // One transfer: predicts the winner and response, then optionally
    // disturbs req/req_data after the save to show they are ignored.
    task automatic xfer(input logic [3:0] r, input int mode, input int lat,
                        input logic rerr, input logic [6:0] rbad, input bit disturb);
        exp_t e;
        int   w;
        bit   tmo;
        bit   ok;
        w    = pick(r);
        last = w;
        load_words();
        req     = r;
        m_mode  = mode;
        m_lat   = lat;
        m_rerr  = rerr;
        m_rdata = rerr ? rbad : words[w];
        tmo     = (mode == M_TMO) || (lat > TIMEOUT);
        e.idx   = w;
        e.word  = words[w];
        e.rdata = tmo ? 7'h00 : m_rdata;
        e.rerr  = tmo ? 1'b1 : rerr;
        e.rto   = tmo;
        e.lat   = tmo ? TIMEOUT + 1 : lat + 1;
        exp_q.push_back(e);
        wait_save(ok);
        if (ok && disturb) begin
            req      = '0;
            req_data = 28'($urandom);
        end
        if (ok) wait_done();
    endtask

    initial begin
        bit ok;
        int x;
        exp_t e;
        for (int i = 0; i < NREQ; i++) words[i] = '0;
        do_reset();

        // Single request
        words[0] = 7'h55;
        xfer(4'b0001, M_NORM, 5, 1'b0, 7'h00, 1'b0);
        req = '0;
        repeat (2) @(negedge clk);

        // Round robin from a fresh reset: expected order 0,1,2,3,0
        do_reset();
        words[0] = 7'h01; words[1] = 7'h02; words[2] = 7'h03; words[3] = 7'h04;
        for (int t = 0; t < 5; t++) begin
            chk("rr_order", 32'(pick(4'b1111)), 32'(t % NREQ));
            xfer(4'b1111, M_NORM, 2 + t, 1'b0, 7'h00, 1'b0);
        end
        req = '0;
        repeat (2) @(negedge clk);

        // Parity error from requester 2
        words[2] = 7'h11;
        xfer(4'b0100, M_NORM, 4, 1'b1, 7'h2A, 1'b0);

        // Timeout, then a normal transfer
        words[1] = 7'h33;
        xfer(4'b0010, M_TMO, 0, 1'b0, 7'h00, 1'b0);
        words[3] = 7'h4C;
        xfer(4'b1000, M_NORM, 3, 1'b0, 7'h00, 1'b0);

        // Stale ready: previous ready still high at save
        words[0] = 7'h6E;
        xfer(4'b0001, M_STALE, 4, 1'b0, 7'h00, 1'b0);

        // Watchdog boundary: ready on the last cycle wins; one later loses
        words[1] = 7'h19;
        xfer(4'b0010, M_NORM, TIMEOUT, 1'b0, 7'h00, 1'b0);
        words[2] = 7'h27;
        xfer(4'b0100, M_NORM, TIMEOUT + 1, 1'b0, 7'h00, 1'b0);
        req = '0;
        repeat (2) @(negedge clk);

        // Reset in the middle of WAIT: no done, next grant to requester 0
        words[0] = 7'h0A; words[1] = 7'h0B; words[2] = 7'h0C; words[3] = 7'h0D;
        load_words();
        req    = 4'b1111;
        m_mode = M_NORM; m_lat = 20; m_rerr = 1'b0; m_rdata = 7'h7F;
        e.idx = pick(4'b1111); e.word = words[e.idx];
        e.rdata = 7'h00; e.rerr = 1'b0; e.rto = 1'b0; e.lat = 0;
        exp_q.push_back(e);
        wait_save(ok);
        repeat (3) @(negedge clk);
        do_reset();
        xfer(4'b1111, M_NORM, 5, 1'b0, 7'h00, 1'b0);

        // Randomized transfers
        for (int t = 0; t < 60; t++) begin
            logic [3:0] r;
            int         mode, lat;
            logic       rerr;
            r = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) words[i] = 7'($urandom);
            x = $urandom_range(0, 9);
            if (x == 0) begin
                mode = M_TMO;  lat = 0;
            end else if (x <= 2) begin
                mode = M_STALE; lat = $urandom_range(3, TIMEOUT - 2);
            end else if (x == 3) begin
                mode = M_NORM; lat = TIMEOUT;
            end else begin
                mode = M_NORM; lat = $urandom_range(2, TIMEOUT - 2);
            end
            rerr = ($urandom_range(0, 4) == 0);
            xfer(r, mode, lat, rerr, 7'($urandom), bit'($urandom_range(0, 1)));
        end
        req = '0;
        repeat (4) @(negedge clk);
        chk("final_idle", 32'(busy), 32'd0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation ran past its time limit, expected to finish");
        $fatal(1, "time limit");
    end

endmodule
